bank_fsm_timed: RTL and testbench

Per-bank control FSM with parametrised widths, bank ID and DRAM timing. It replaces the untimed bank FSM and adds tRCD/tRP/tRAS/tWR enforcement, a page policy choice, explicit precharge on auto-precharge, and optional refresh handshaking. One instance per bank sits between the command dispatcher and the shared command-bus arbiter, which drives stall.

---
 rtl/bank_fsm_timed_if.sv | 34 +++
 rtl/bank_fsm_timed.sv | 225 ++++++++++++++++++++++
 tb/tb_bank_fsm_timed.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bank_fsm_timed_if.sv
// Signals between one bank FSM, the command dispatcher and the command-bus arbiter.
// Latency: none, wiring only. Backpressure: cmd_ready from the bank, stall from the arbiter.
interface bank_fsm_timed_if #(
    parameter int ROW_BITS = 14,
    parameter int COL_BITS = 14,
    parameter int BA_BITS  = 3
);
    localparam int ADDR_BITS = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS;
    localparam int CMD_BITS  = 1 + ROW_BITS + COL_BITS + BA_BITS;

    logic                 init_done;
    logic                 cmd_valid;
    logic [CMD_BITS-1:0]  cmd_data;
    logic                 cmd_ready;
    logic                 stall;
    logic [3:0]           ba_state;
    logic                 ba_busy;
    logic                 ba_issue;
    logic [1:0]           ba_cmd;
    logic [ADDR_BITS-1:0] ba_addr;
    logic [1:0]           process_cmd;
    logic                 ref_req;
    logic                 ref_ack;

    modport master (
        output init_done, cmd_valid, cmd_data, stall, ref_req,
        input  cmd_ready, ba_state, ba_busy, ba_issue, ba_cmd, ba_addr, process_cmd, ref_ack
    );

    modport slave (
        input  init_done, cmd_valid, cmd_data, stall, ref_req,
        output cmd_ready, ba_state, ba_busy, ba_issue, ba_cmd, ba_addr, process_cmd, ref_ack
    );
endinterface

// File: rtl/bank_fsm_timed.sv
// Per-bank DRAM control FSM enforcing tRCD/tRP/tRAS/tWR, open/closed page and auto-precharge.
// Latency: ACT two cycles after accept from an idle bank, RD/WR TRCD cycles after ACT.
// Backpressure: cmd_ready only in IDLE/STANDBY; arbiter stall holds the *_CHK states. Refresh via BANK_REF_EN.
module bank_fsm_timed #(
    parameter int ROW_BITS    = 14,
    parameter int COL_BITS    = 14,
    parameter int BA_BITS     = 3,
    parameter int BANK_ID     = 0,
    parameter int AP_BIT      = 10,
    parameter int PAGE_POLICY = 0,
    parameter int TRCD        = 3,
    parameter int TRP         = 3,
    parameter int TRAS        = 6,
    parameter int TWR         = 4,
    parameter int TCNT_BITS   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    bank_fsm_timed_if.slave bus
);
    localparam int ADDR_BITS = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS;

    localparam logic [1:0] BC_NOP = 2'b00;
    localparam logic [1:0] BC_ACT = 2'b01;
    localparam logic [1:0] BC_RD  = 2'b10;
    localparam logic [1:0] BC_WR  = 2'b11;

    localparam logic [1:0] PC_NONE  = 2'b00;
    localparam logic [1:0] PC_READ  = 2'b01;
    localparam logic [1:0] PC_WRITE = 2'b10;

    typedef enum logic [3:0] {
        S_INIT    = 4'd0,
        S_IDLE    = 4'd1,
        S_ACT_CHK = 4'd2,
        S_ACTIVE  = 4'd3,
        S_RD_CHK  = 4'd4,
        S_WR_CHK  = 4'd5,
        S_READ    = 4'd6,
        S_WRITE   = 4'd7,
        S_STANDBY = 4'd8,
        S_PRE_CHK = 4'd9,
        S_PRE     = 4'd10
    } state_e;

    state_e                 state_q, state_d;
    logic [TCNT_BITS-1:0]   tcnt_q, tcnt_d;
    logic [TCNT_BITS-1:0]   tras_q, tras_d;
    logic [TCNT_BITS-1:0]   twr_q, twr_d;
    logic                   cmd_rw_q, cmd_rw_d;
    logic [ROW_BITS-1:0]    cmd_row_q, cmd_row_d;
    logic [COL_BITS-1:0]    cmd_col_q, cmd_col_d;
    logic [ROW_BITS-1:0]    act_row_q, act_row_d;
    logic                   close_q, close_d;
    logic [1:0]             proc_q, proc_d;

    logic                   issue;
    logic [1:0]             bcmd;
    logic [ADDR_BITS-1:0]   addr;

    logic                   in_rw;
    logic [ROW_BITS-1:0]    in_row;
    logic [COL_BITS-1:0]    in_col;
    logic [BA_BITS-1:0]     in_bank;

    assign {in_rw, in_row, in_col, in_bank} = bus.cmd_data;

    logic ref_pend;
`ifdef BANK_REF_EN
    assign ref_pend = bus.ref_req;
`else
    logic ref_req_unused;
    assign ref_pend       = 1'b0;
    assign ref_req_unused = bus.ref_req;
`endif

    logic quiet_state;
    logic rdy;
    logic accept;
    logic row_hit;
    logic tcnt_zero;
    logic pre_ok;
    logic close_after;

    assign quiet_state = (state_q == S_IDLE) || (state_q == S_STANDBY);
    // A pending refresh blocks new commands so it cannot be starved.
    assign rdy         = quiet_state && !ref_pend;
    assign accept      = bus.cmd_valid && (in_bank == BA_BITS'(BANK_ID)) && rdy;
    assign row_hit     = (in_row == act_row_q);
    assign tcnt_zero   = (tcnt_q == '0);
    assign pre_ok      = !bus.stall && (tras_q == '0) && (twr_q == '0);
    assign close_after = (PAGE_POLICY == 1) || cmd_col_q[AP_BIT];

    function automatic logic [TCNT_BITS-1:0] dec_sat(input logic [TCNT_BITS-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        tcnt_d    = dec_sat(tcnt_q);
        tras_d    = dec_sat(tras_q);
        twr_d     = dec_sat(twr_q);
        cmd_rw_d  = cmd_rw_q;
        cmd_row_d = cmd_row_q;
        cmd_col_d = cmd_col_q;
        act_row_d = act_row_q;
        close_d   = close_q;
        proc_d    = proc_q;
        issue     = 1'b0;
        bcmd      = BC_NOP;
        addr      = '0;

        if (accept) begin
            cmd_rw_d  = in_rw;
            cmd_row_d = in_row;
            cmd_col_d = in_col;
            proc_d    = in_rw ? PC_READ : PC_WRITE;
        end

        case (state_q)
            S_INIT: begin
                if (bus.init_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (accept) state_d = S_ACT_CHK;
            end
            S_ACT_CHK: begin
                if (!bus.stall && tcnt_zero) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                issue     = 1'b1;
                bcmd      = BC_ACT;
                addr      = ADDR_BITS'(cmd_row_q);
                act_row_d = cmd_row_q;
                // Loads are minus two: one cycle in this state, one for the CHK exit.
                tcnt_d    = TCNT_BITS'(TRCD - 2);
                tras_d    = TCNT_BITS'(TRAS - 2);
                state_d   = cmd_rw_q ? S_RD_CHK : S_WR_CHK;
            end
            S_RD_CHK: begin
                if (!bus.stall && tcnt_zero) state_d = S_READ;
            end
            S_WR_CHK: begin
                if (!bus.stall && tcnt_zero) state_d = S_WRITE;
            end
            S_READ, S_WRITE: begin
                issue = 1'b1;
                bcmd  = (state_q == S_READ) ? BC_RD : BC_WR;
                addr  = ADDR_BITS'(cmd_col_q);
                if (state_q == S_WRITE) twr_d = TCNT_BITS'(TWR - 2);
                if (close_after) begin
                    state_d = S_PRE_CHK;
                    close_d = 1'b1;
                end else begin
                    state_d = S_STANDBY;
                    proc_d  = PC_NONE;
                end
            end
            S_STANDBY: begin
                if (accept) begin
                    if (row_hit) begin
                        state_d = in_rw ? S_RD_CHK : S_WR_CHK;
                    end else begin
                        state_d = S_PRE_CHK;
                        close_d = 1'b0;
                    end
                end else if (ref_pend) begin
                    state_d = S_PRE_CHK;
                    close_d = 1'b1;
                end
            end
            S_PRE_CHK: begin
                if (pre_ok) state_d = S_PRE;
            end
            S_PRE: begin
                issue  = 1'b1;
                bcmd   = BC_NOP;
                tcnt_d = TCNT_BITS'(TRP - 2);
                if (close_q) begin
                    state_d = S_IDLE;
                    proc_d  = PC_NONE;
                end else begin
                    // Row miss: reopen with the command latched in STANDBY.
                    state_d = S_ACT_CHK;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            tcnt_q    <= '0;
            tras_q    <= '0;
            twr_q     <= '0;
            cmd_rw_q  <= 1'b0;
            cmd_row_q <= '0;
            cmd_col_q <= '0;
            act_row_q <= '0;
            close_q   <= 1'b0;
            proc_q    <= PC_NONE;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            tras_q    <= tras_d;
            twr_q     <= twr_d;
            cmd_rw_q  <= cmd_rw_d;
            cmd_row_q <= cmd_row_d;
            cmd_col_q <= cmd_col_d;
            act_row_q <= act_row_d;
            close_q   <= close_d;
            proc_q    <= proc_d;
        end
    end

    assign bus.ba_state    = state_q;
    assign bus.ba_busy     = !quiet_state;
    assign bus.ba_issue    = issue;
    assign bus.ba_cmd      = bcmd;
    assign bus.ba_addr     = addr;
    assign bus.cmd_ready   = rdy;
    assign bus.process_cmd = proc_q;
    assign bus.ref_ack     = (state_q == S_IDLE) && tcnt_zero && ref_pend;
endmodule

// File: tb/tb_bank_fsm_timed.sv
// Directed bench: per-cycle vector table on an open-page bank, plus closed-page, refresh and reset sequences.
module tb_bank_fsm_timed;
    localparam int RB = 14;
    localparam int CB = 14;
    localparam int BB = 3;
    localparam int AB = 14;

    localparam int S_INIT = 0, S_IDLE = 1, S_ACT_CHK = 2, S_ACTIVE = 3, S_RD_CHK = 4, S_WR_CHK = 5;
    localparam int S_READ = 6, S_WRITE = 7, S_STANDBY = 8, S_PRE_CHK = 9, S_PRE = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bank_fsm_timed_if #(.ROW_BITS(RB), .COL_BITS(CB), .BA_BITS(BB)) if0 ();
    bank_fsm_timed_if #(.ROW_BITS(RB), .COL_BITS(CB), .BA_BITS(BB)) if1 ();

    bank_fsm_timed #(.ROW_BITS(RB), .COL_BITS(CB), .BA_BITS(BB), .PAGE_POLICY(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    bank_fsm_timed #(.ROW_BITS(RB), .COL_BITS(CB), .BA_BITS(BB), .PAGE_POLICY(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        logic          valid;
        logic          rw;
        logic [RB-1:0] row;
        logic [CB-1:0] col;
        logic [BB-1:0] bank;
        logic          stall;
        logic [3:0]    st;
        logic          issue;
        logic [1:0]    bcmd;
        logic [AB-1:0] addr;
        logic [1:0]    proc;
    } vec_t;

    vec_t        tv[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [25:0] got, want;
    logic        exp_quiet;

    function automatic vec_t mk(input int v, input int rw, input int row, input int col, input int bank,
                                input int stl, input int st, input int iss, input int bc, input int addr,
                                input int pr);
        vec_t m;
        m.valid = 1'(v);   m.rw = 1'(rw);      m.row = RB'(row);  m.col = CB'(col);
        m.bank  = BB'(bank); m.stall = 1'(stl); m.st = 4'(st);     m.issue = 1'(iss);
        m.bcmd  = 2'(bc);  m.addr = AB'(addr); m.proc = 2'(pr);
        return m;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, " state"}, int'(if0.ba_state), S_INIT);
        chk({pfx, " busy"}, int'(if0.ba_busy), 1);
        chk({pfx, " issue"}, int'(if0.ba_issue), 0);
        chk({pfx, " cmd"}, int'(if0.ba_cmd), 0);
        chk({pfx, " addr"}, int'(if0.ba_addr), 0);
        chk({pfx, " ready"}, int'(if0.cmd_ready), 0);
        chk({pfx, " proc"}, int'(if0.process_cmd), 0);
        chk({pfx, " ref_ack"}, int'(if0.ref_ack), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int  iss_cmd[8], iss_addr[8], iss_cyc[8];
    int  n_iss;
    bit  done;

    initial begin
        rst_n = 1'b0;
        if0.init_done = 1'b0; if0.cmd_valid = 1'b0; if0.cmd_data = '0; if0.stall = 1'b0; if0.ref_req = 1'b0;
        if1.init_done = 1'b0; if1.cmd_valid = 1'b0; if1.cmd_data = '0; if1.stall = 1'b0; if1.ref_req = 1'b0;

        // valid rw row col bank stall | state issue cmd addr proc
        tv.push_back(mk(0,0,0,0,0,0,    S_INIT,   0,0,0,0));
        tv.push_back(mk(1,1,5,8,0,0,    S_IDLE,   0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,    S_ACT_CHK,0,0,0,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_ACTIVE, 1,1,5,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_RD_CHK, 0,0,0,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_RD_CHK, 0,0,0,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_READ,   1,2,8,1));
        tv.push_back(mk(1,1,5,12,0,0,   S_STANDBY,0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,    S_RD_CHK, 0,0,0,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_READ,   1,2,12,1));
        tv.push_back(mk(1,1,9,3,0,0,    S_STANDBY,0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,    S_PRE_CHK,0,0,0,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_PRE,    1,0,0,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_ACT_CHK,0,0,0,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_ACT_CHK,0,0,0,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_ACTIVE, 1,1,9,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_RD_CHK, 0,0,0,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_RD_CHK, 0,0,0,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_READ,   1,2,3,1));
        tv.push_back(mk(1,0,9,1028,0,0, S_STANDBY,0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,    S_WR_CHK, 0,0,0,2));
        tv.push_back(mk(0,0,0,0,0,0,    S_WRITE,  1,3,1028,2));
        tv.push_back(mk(0,0,0,0,0,0,    S_PRE_CHK,0,0,0,2));
        tv.push_back(mk(0,0,0,0,0,0,    S_PRE_CHK,0,0,0,2));
        tv.push_back(mk(0,0,0,0,0,0,    S_PRE_CHK,0,0,0,2));
        tv.push_back(mk(0,0,0,0,0,0,    S_PRE,    1,0,0,2));
        tv.push_back(mk(1,1,7,1,2,0,    S_IDLE,   0,0,0,0));
        tv.push_back(mk(1,1,3,5,0,0,    S_IDLE,   0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,    S_ACT_CHK,0,0,0,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_ACTIVE, 1,1,3,1));
        for (int k = 0; k < 5; k++)
            tv.push_back(mk(0,0,0,0,0,1, S_RD_CHK,0,0,0,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_RD_CHK, 0,0,0,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_READ,   1,2,5,1));
        tv.push_back(mk(0,0,0,0,0,0,    S_STANDBY,0,0,0,0));

        repeat (2) @(negedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        if1.init_done = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            if0.cmd_valid = tv[i].valid;
            if0.cmd_data  = {tv[i].rw, tv[i].row, tv[i].col, tv[i].bank};
            if0.stall     = tv[i].stall;
            #1;
            exp_quiet = (tv[i].st == 4'(S_IDLE)) || (tv[i].st == 4'(S_STANDBY));
            got  = {if0.ba_state, if0.ba_busy, if0.ba_issue, if0.ba_cmd, if0.ba_addr,
                    if0.cmd_ready, if0.process_cmd, if0.ref_ack};
            want = {tv[i].st, !exp_quiet, tv[i].issue, tv[i].bcmd, tv[i].addr,
                    exp_quiet, tv[i].proc, 1'b0};
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL vec[%0d]: got state=%0d busy=%0b issue=%0b cmd=%0d addr=%0d ready=%0b proc=%0d ack=%0b, expected state=%0d busy=%0b issue=%0b cmd=%0d addr=%0d ready=%0b proc=%0d ack=0",
                         i, if0.ba_state, if0.ba_busy, if0.ba_issue, if0.ba_cmd, if0.ba_addr, if0.cmd_ready,
                         if0.process_cmd, if0.ref_ack, tv[i].st, !exp_quiet, tv[i].issue, tv[i].bcmd,
                         tv[i].addr, exp_quiet, tv[i].proc);
            end
            if0.init_done = 1'b1;
        end

        // Closed page: read without auto-precharge bit still closes the row.
        if1.cmd_valid = 1'b1;
        if1.cmd_data  = {1'b1, 14'd4, 14'd2, 3'd0};
        n_iss = 0;
        done  = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if1.cmd_valid = 1'b0;
            #1;
            if (if1.ba_issue && n_iss < 8) begin
                iss_cmd[n_iss]  = int'(if1.ba_cmd);
                iss_addr[n_iss] = int'(if1.ba_addr);
                iss_cyc[n_iss]  = k;
                n_iss++;
            end
            if (n_iss >= 3 && int'(if1.ba_state) == S_IDLE) done = 1'b1;
        end
        chk("closed issue count", n_iss, 3);
        chk("closed ACT cmd", iss_cmd[0], 1);
        chk("closed ACT row", iss_addr[0], 4);
        chk("closed RD cmd", iss_cmd[1], 2);
        chk("closed RD col", iss_addr[1], 2);
        chk("closed ACT->RD", iss_cyc[1] - iss_cyc[0], 3);
        chk("closed PRE cmd", iss_cmd[2], 0);
        chk("closed ACT->PRE", iss_cyc[2] - iss_cyc[0], 6);
        chk("closed final state", int'(if1.ba_state), S_IDLE);
        chk("closed final proc", int'(if1.process_cmd), 0);

`ifdef BANK_REF_EN
        @(negedge clk);
        if0.ref_req = 1'b1;
        #1;
        chk("ref ready blocked", int'(if0.cmd_ready), 0);
        n_iss = 0;
        done  = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            @(negedge clk);
            #1;
            if (if0.ba_issue && int'(if0.ba_cmd) == 0) n_iss++;
            if (int'(if0.ba_state) == S_IDLE) done = 1'b1;
        end
        chk("ref reached IDLE", int'(done), 1);
        chk("ref PRE count", n_iss, 1);
        chk("ref_ack during tRP", int'(if0.ref_ack), 0);
        chk("ref ready in IDLE", int'(if0.cmd_ready), 0);
        @(negedge clk);
        #1;
        chk("ref_ack after tRP", int'(if0.ref_ack), 1);
        chk("ref ready held", int'(if0.cmd_ready), 0);
        if0.ref_req = 1'b0;
        #1;
        chk("ref_ack dropped", int'(if0.ref_ack), 0);
        chk("ready after ref", int'(if0.cmd_ready), 1);
`else
        @(negedge clk);
        if0.ref_req = 1'b1;
        #1;
        chk("ref ignored ready", int'(if0.cmd_ready), 1);
        chk("ref ignored ack", int'(if0.ref_ack), 0);
        @(negedge clk);
        #1;
        chk("ref ignored state", int'(if0.ba_state), S_STANDBY);
        if0.ref_req = 1'b0;
`endif

        // Async reset while waiting in RD_CHK.
        if0.cmd_valid = 1'b1;
        if0.cmd_data  = {1'b1, 14'd6, 14'd2, 3'd0};
        done = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            @(negedge clk);
            if0.cmd_valid = 1'b0;
            #1;
            if (int'(if0.ba_state) == S_RD_CHK) done = 1'b1;
        end
        chk("reached RD_CHK", int'(done), 1);
        chk("proc before reset", int'(if0.process_cmd), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("mid reset");
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("held reset no issue", int'(if0.ba_issue), 0);
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
